terminal_event_queue: RTL and testbench

Parametrised input-event concentrator between the terminal input sources (debounced buttons, PS/2 keyboard decoder, future UART/macro sources) and `terminal_controller`. Accepts one-cycle event pulses from `N_SRC` independent sources, serialises them with a round-robin arbiter into a first-word-fall-through FIFO, and presents them on a valid/ready stream. Adds typematic auto-repeat for held CHAR/BKSP keys, so callers no longer OR button and keyboard strobes together.

---
 rtl/terminal_event_queue_if.sv | 33 +++
 rtl/terminal_event_queue.sv | 176 +++++++++++++++++
 tb/tb_terminal_event_queue.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/terminal_event_queue_if.sv
// Event-queue stream bundle: per-source event inputs and the serialised output stream.
// The slave modport is the queue itself; master is whatever drives the sources and consumes events.
interface terminal_event_queue_if #(
  parameter int N_SRC      = 4,
  parameter int DEPTH      = 16,
  parameter int CHAR_WIDTH = 16
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_SRC-1:0]            src_valid_in;
  logic [2*N_SRC-1:0]          src_kind_in;
  logic [CHAR_WIDTH*N_SRC-1:0] src_char_in;
  logic [N_SRC-1:0]            src_held_in;
  logic                        repeat_en_in;
  logic                        ev_valid_out;
  logic                        ev_ready_in;
  logic [1:0]                  ev_kind_out;
  logic [CHAR_WIDTH-1:0]       ev_char_out;
  logic [SW-1:0]               ev_src_out;
  logic [CW-1:0]               count_out;
  logic [7:0]                  drop_count_out;

  modport master (
    output src_valid_in, src_kind_in, src_char_in, src_held_in, repeat_en_in, ev_ready_in,
    input  ev_valid_out, ev_kind_out, ev_char_out, ev_src_out, count_out, drop_count_out
  );

  modport slave (
    input  src_valid_in, src_kind_in, src_char_in, src_held_in, repeat_en_in, ev_ready_in,
    output ev_valid_out, ev_kind_out, ev_char_out, ev_src_out, count_out, drop_count_out
  );
endinterface

// File: rtl/terminal_event_queue.sv
// Terminal input concentrator: per-source pending slots, round-robin arbiter, FWFT FIFO
// and a typematic auto-repeat engine for held CHAR/BKSP keys.
module terminal_event_queue #(
  parameter int N_SRC         = 4,
  parameter int DEPTH         = 16,
  parameter int CHAR_WIDTH    = 16,
  parameter int REPEAT_DELAY  = 37125000,
  parameter int REPEAT_PERIOD = 2475000
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  terminal_event_queue_if.slave ev_if
);
  localparam int SW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int DW   = $clog2(N_SRC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);

  localparam logic [1:0] K_CHAR  = 2'd0;
  localparam logic [1:0] K_ENTER = 2'd1;
  localparam logic [1:0] K_BKSP  = 2'd2;
  localparam logic [1:0] K_CTRL  = 2'd3;

  typedef enum logic {S_IDLE, S_ARMED} rpt_state_t;

  logic [N_SRC-1:0]      r_slot_vld;
  logic [N_SRC-1:0]      r_slot_rpt;
  logic [1:0]            r_slot_kind [N_SRC];
  logic [CHAR_WIDTH-1:0] r_slot_char [N_SRC];
  logic [SW-1:0]         r_last;

  logic [SW-1:0]         r_mem_src  [DEPTH];
  logic [1:0]            r_mem_kind [DEPTH];
  logic [CHAR_WIDTH-1:0] r_mem_char [DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_drop;

  rpt_state_t            r_state;
  logic [SW-1:0]         r_rpt_src;
  logic [1:0]            r_rpt_kind;
  logic [CHAR_WIDTH-1:0] r_rpt_char;
  logic [TW-1:0]         r_timer;

  logic                  w_valid, w_pop, w_accept, w_push;
  logic                  w_gnt_any;
  logic [SW-1:0]         w_gnt_idx, w_cand;
  logic [N_SRC-1:0]      w_free, w_load_raw, w_load_inj;
  logic [DW-1:0]         w_drop_n;
  logic [1:0]            w_wr_kind;
  logic                  w_wr_rpt, w_arm, w_disarm_wr, w_hold_ok, w_inj;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [DW-1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + 9'(b);
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & ev_if.ev_ready_in;
  assign w_accept = (r_count < CW'(DEPTH)) | w_pop;
  assign w_push   = w_gnt_any & w_accept;

  // Round-robin search starting one past the last granted source
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      w_cand = SW'((int'(r_last) + i) % N_SRC);
      if (!w_gnt_any && r_slot_vld[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_wr_kind   = r_slot_kind[w_gnt_idx];
  assign w_wr_rpt    = r_slot_rpt[w_gnt_idx];
  assign w_arm       = w_push & ~w_wr_rpt & ((w_wr_kind == K_CHAR) | (w_wr_kind == K_BKSP))
                       & ev_if.repeat_en_in;
  assign w_disarm_wr = w_push & ~w_wr_rpt & ((w_wr_kind == K_ENTER) | (w_wr_kind == K_CTRL));
  assign w_hold_ok   = ev_if.src_held_in[r_rpt_src] & ev_if.repeat_en_in;
  assign w_inj       = (r_state == S_ARMED) & ~w_arm & ~w_disarm_wr & w_hold_ok
                       & (r_timer == TW'(1));

  // A slot is free if empty or being granted this edge; raw pulses beat injections
  always_comb begin
    w_free     = '0;
    w_load_raw = '0;
    w_load_inj = '0;
    w_drop_n   = '0;
    for (int s = 0; s < N_SRC; s++) begin
      w_free[s]     = ~r_slot_vld[s] | (w_push & (w_gnt_idx == SW'(s)));
      w_load_raw[s] = ev_if.src_valid_in[s] & w_free[s];
      w_load_inj[s] = w_inj & (r_rpt_src == SW'(s)) & ~ev_if.src_valid_in[s] & w_free[s];
      if (ev_if.src_valid_in[s] & ~w_free[s]) w_drop_n = w_drop_n + DW'(1);
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_slot_vld <= '0;
      r_last     <= SW'(N_SRC - 1);
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_drop     <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++) begin
        if (w_load_raw[s] | w_load_inj[s]) r_slot_vld[s] <= 1'b1;
        else if (w_free[s])                r_slot_vld[s] <= 1'b0;
      end
      if (w_push) r_last <= w_gnt_idx;
      if (w_push) r_wr   <= r_wr + PW'(1);
      if (w_pop)  r_rd   <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_drop <= sat_add8(r_drop, w_drop_n);
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    for (int s = 0; s < N_SRC; s++) begin
      if (w_load_raw[s]) begin
        r_slot_kind[s] <= ev_if.src_kind_in[2*s +: 2];
        r_slot_char[s] <= ev_if.src_char_in[CHAR_WIDTH*s +: CHAR_WIDTH];
        r_slot_rpt[s]  <= 1'b0;
      end else if (w_load_inj[s]) begin
        r_slot_kind[s] <= r_rpt_kind;
        r_slot_char[s] <= r_rpt_char;
        r_slot_rpt[s]  <= 1'b1;
      end
    end
    if (w_push) begin
      r_mem_src[r_wr]  <= w_gnt_idx;
      r_mem_kind[r_wr] <= w_wr_kind;
      r_mem_char[r_wr] <= r_slot_char[w_gnt_idx];
    end
    if (w_arm) begin
      r_rpt_src  <= w_gnt_idx;
      r_rpt_kind <= w_wr_kind;
      r_rpt_char <= r_slot_char[w_gnt_idx];
    end
  end

  // Repeat engine: timer==1 marks the injection edge, then reloads the period
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else if (w_arm) begin
      r_state <= S_ARMED;
      r_timer <= TW'(REPEAT_DELAY);
    end else if (w_disarm_wr) begin
      r_state <= S_IDLE;
    end else if (r_state == S_ARMED) begin
      if (!w_hold_ok)                r_state <= S_IDLE;
      else if (r_timer == TW'(1))    r_timer <= TW'(REPEAT_PERIOD);
      else                           r_timer <= r_timer - TW'(1);
    end
  end

  assign ev_if.ev_valid_out   = w_valid;
  assign ev_if.ev_kind_out    = w_valid ? r_mem_kind[r_rd] : '0;
  assign ev_if.ev_char_out    = w_valid ? r_mem_char[r_rd] : '0;
  assign ev_if.ev_src_out     = w_valid ? r_mem_src[r_rd]  : '0;
  assign ev_if.count_out      = r_count;
  assign ev_if.drop_count_out = r_drop;
endmodule

// File: tb/tb_terminal_event_queue.sv
// Bench for terminal_event_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model with an absolute-time repeat schedule.
module tb_terminal_event_queue;
  localparam int N   = 4;
  localparam int D   = 4;
  localparam int CWD = 16;
  localparam int RD  = 10;
  localparam int RP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  terminal_event_queue_if #(.N_SRC(N), .DEPTH(D), .CHAR_WIDTH(CWD)) bus();

  terminal_event_queue #(
    .N_SRC(N), .DEPTH(D), .CHAR_WIDTH(CWD), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .ev_if        (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { int src; int kind; int chr; } ev_t;
  ev_t    m_q[$];
  bit     m_occ  [N];
  int     m_kind [N];
  int     m_char [N];
  bit     m_rpt  [N];
  int     m_last, m_drop;
  bit     m_armed;
  int     m_rsrc, m_rkind, m_rchar;
  longint m_next, m_cyc;

  task automatic model_reset();
    m_q.delete();
    for (int s = 0; s < N; s++) begin m_occ[s] = 0; m_kind[s] = 0; m_char[s] = 0; m_rpt[s] = 0; end
    m_last = N - 1; m_drop = 0; m_armed = 0; m_rsrc = 0; m_rkind = 0; m_rchar = 0;
    m_next = 0; m_cyc = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied
  task automatic model_step();
    bit pop, acc, wr, free;
    int g, k, wk, inj, drops;
    ev_t e;
    pop = (m_q.size() > 0) && bus.ev_ready_in;
    acc = (m_q.size() < D) || pop;
    g = -1;
    if (acc)
      for (int i = 1; i <= N; i++) begin
        k = (m_last + i) % N;
        if (g < 0 && m_occ[k]) g = k;
      end
    wk = 0; wr = 1; e = '{0, 0, 0};
    if (g >= 0) begin
      e = '{g, m_kind[g], m_char[g]};
      wk = m_kind[g]; wr = m_rpt[g]; m_last = g;
    end
    inj = -1;
    if (g >= 0 && !wr && (wk == 0 || wk == 2) && bus.repeat_en_in) begin
      m_armed = 1; m_rsrc = g; m_rkind = wk; m_rchar = m_char[g]; m_next = m_cyc + RD;
    end else if (g >= 0 && !wr && (wk == 1 || wk == 3)) begin
      m_armed = 0;
    end else if (m_armed) begin
      if (!bus.src_held_in[m_rsrc] || !bus.repeat_en_in) m_armed = 0;
      else if (m_cyc == m_next) begin inj = m_rsrc; m_next = m_cyc + RP; end
    end
    drops = 0;
    for (int s = 0; s < N; s++) begin
      free = !m_occ[s] || (g == s);
      if (bus.src_valid_in[s]) begin
        if (free) begin
          m_occ[s] = 1; m_rpt[s] = 0;
          m_kind[s] = int'(bus.src_kind_in[2*s +: 2]);
          m_char[s] = int'(bus.src_char_in[CWD*s +: CWD]);
        end else drops++;
      end else if (inj == s && free) begin
        m_occ[s] = 1; m_rpt[s] = 1; m_kind[s] = m_rkind; m_char[s] = m_rchar;
      end else if (g == s) m_occ[s] = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(e);
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    bus.src_valid_in = '0;
  endtask

  task automatic set_pulse(input int s, input int kind, input int ch);
    bus.src_valid_in[s]          = 1'b1;
    bus.src_kind_in[2*s +: 2]    = 2'(kind);
    bus.src_char_in[CWD*s +: CWD] = 16'(ch);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.src_valid_in = '0; bus.src_held_in = '0; bus.repeat_en_in = 1'b0; bus.ev_ready_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.ev_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.ev_valid_out); end
    total++; if (bus.count_out !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count_out); end
    total++; if (bus.drop_count_out !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", bus.drop_count_out); end
    total++; if (bus.ev_char_out !== 16'd0 || bus.ev_kind_out !== 2'd0 || bus.ev_src_out !== 2'd0) begin
      bad++; $display("FAIL rst_head got=%0h/%0d/%0d want=0/0/0", bus.ev_char_out, bus.ev_kind_out, bus.ev_src_out);
    end
  endtask

  task automatic test_single_event();
    do_reset();
    set_pulse(1, 0, 'h41);
    tick();
    total++; if (bus.ev_valid_out !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", bus.ev_valid_out); end
    tick();
    total++; if (bus.ev_valid_out !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", bus.ev_valid_out); end
    total++; if (bus.ev_char_out !== 16'h0041) begin bad++; $display("FAIL single_char got=%0h want=41", bus.ev_char_out); end
    total++; if (bus.ev_src_out !== 2'd1 || bus.ev_kind_out !== 2'd0) begin
      bad++; $display("FAIL single_srckind got=%0d/%0d want=1/0", bus.ev_src_out, bus.ev_kind_out);
    end
    total++; if (bus.count_out !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.count_out); end
    bus.ev_ready_in = 1'b1;
    tick();
    bus.ev_ready_in = 1'b0;
    total++; if (bus.count_out !== 3'd0 || bus.ev_valid_out !== 1'b0) begin
      bad++; $display("FAIL single_pop got=%0d/%0b want=0/0", bus.count_out, bus.ev_valid_out);
    end
    total++; if (bus.ev_char_out !== 16'd0 || bus.ev_src_out !== 2'd0) begin
      bad++; $display("FAIL single_headzero got=%0h/%0d want=0/0", bus.ev_char_out, bus.ev_src_out);
    end
  endtask

  task automatic test_round_robin();
    int exp1[3];
    int exp2[2];
    exp1 = '{0, 2, 3};
    exp2 = '{0, 2};
    do_reset();
    set_pulse(0, 0, 'hA0); set_pulse(2, 0, 'hA2); set_pulse(3, 0, 'hA3);
    repeat (4) tick();
    total++; if (bus.count_out !== 3'd3) begin bad++; $display("FAIL rr_count got=%0d want=3", bus.count_out); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.ev_src_out !== 2'(exp1[i])) begin bad++; $display("FAIL rr_order1[%0d] got=%0d want=%0d", i, bus.ev_src_out, exp1[i]); end
      bus.ev_ready_in = 1'b1; tick(); bus.ev_ready_in = 1'b0;
    end
    set_pulse(0, 0, 'hB0); set_pulse(2, 0, 'hB2);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.ev_src_out !== 2'(exp2[i])) begin bad++; $display("FAIL rr_order2[%0d] got=%0d want=%0d", i, bus.ev_src_out, exp2[i]); end
      bus.ev_ready_in = 1'b1; tick(); bus.ev_ready_in = 1'b0;
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_pulse(0, 0, 'h100 + i);
      repeat (3) tick();
    end
    total++; if (bus.count_out !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.count_out); end
    total++; if (bus.drop_count_out !== 8'd1) begin bad++; $display("FAIL full_drop got=%0d want=1", bus.drop_count_out); end
    bus.ev_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.ev_valid_out !== 1'b1 || bus.ev_char_out !== 16'(32'h100 + i)) begin
        bad++; $display("FAIL full_drain[%0d] got=%0b/%0h want=1/%0h", i, bus.ev_valid_out, bus.ev_char_out, 32'h100 + i);
      end
      tick();
    end
    bus.ev_ready_in = 1'b0;
    total++; if (bus.ev_valid_out !== 1'b0) begin bad++; $display("FAIL full_empty got=%0b want=0", bus.ev_valid_out); end
  endtask

  task automatic test_auto_repeat();
    int kinds[3];
    int holds[3];
    int expn[3];
    int n, charbad;
    kinds = '{0, 1, 0};
    holds = '{25, 25, 11};
    expn  = '{5, 1, 2};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      bus.repeat_en_in = 1'b1; bus.ev_ready_in = 1'b1; bus.src_held_in[0] = 1'b1;
      set_pulse(0, kinds[v], 'h61);
      n = 0; charbad = 0;
      tick();
      tick();
      for (int j = 0; j < holds[v] + 20; j++) begin
        if (j == holds[v]) bus.src_held_in[0] = 1'b0;
        if (bus.ev_valid_out === 1'b1) begin
          n++;
          if (bus.ev_char_out !== 16'h0061) charbad++;
        end
        tick();
      end
      total++; if (n != expn[v]) begin bad++; $display("FAIL repeat_count[%0d] got=%0d want=%0d", v, n, expn[v]); end
      total++; if (charbad != 0) begin bad++; $display("FAIL repeat_char[%0d] got=%0d bad chars want=0", v, charbad); end
    end
    bus.repeat_en_in = 1'b0; bus.ev_ready_in = 1'b0;
  endtask

  task automatic test_full_boundary();
    int expc[4];
    expc = '{'h11, 'h12, 'h13, 'h20};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_pulse(1, 0, 'h10 + i);
      tick();
    end
    tick();
    total++; if (bus.count_out !== 3'd4) begin bad++; $display("FAIL bnd_full got=%0d want=4", bus.count_out); end
    set_pulse(2, 0, 'h20);
    tick();
    total++; if (bus.count_out !== 3'd4) begin bad++; $display("FAIL bnd_pending got=%0d want=4", bus.count_out); end
    bus.ev_ready_in = 1'b1; tick(); bus.ev_ready_in = 1'b0;
    total++; if (bus.count_out !== 3'd4) begin bad++; $display("FAIL bnd_pushpop got=%0d want=4", bus.count_out); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ev_char_out !== 16'(expc[i])) begin bad++; $display("FAIL bnd_order[%0d] got=%0h want=%0h", i, bus.ev_char_out, expc[i]); end
      bus.ev_ready_in = 1'b1; tick(); bus.ev_ready_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.repeat_en_in = 1'b1; bus.src_held_in[0] = 1'b1;
    set_pulse(0, 0, 'h70); set_pulse(1, 0, 'h71); set_pulse(2, 0, 'h72);
    tick();
    set_pulse(1, 0, 'h81); set_pulse(2, 0, 'h82);
    tick();
    tick();
    tick();
    total++; if (bus.count_out !== 3'd3) begin bad++; $display("FAIL mid_count got=%0d want=3", bus.count_out); end
    total++; if (bus.drop_count_out !== 8'd2) begin bad++; $display("FAIL mid_drop got=%0d want=2", bus.drop_count_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.ev_valid_out !== 1'b0 || bus.count_out !== 3'd0 || bus.drop_count_out !== 8'd0) begin
      bad++; $display("FAIL mid_async got=%0b/%0d/%0d want=0/0/0", bus.ev_valid_out, bus.count_out, bus.drop_count_out);
    end
    total++; if (bus.ev_char_out !== 16'd0 || bus.ev_kind_out !== 2'd0 || bus.ev_src_out !== 2'd0) begin
      bad++; $display("FAIL mid_head got=%0h/%0d/%0d want=0/0/0", bus.ev_char_out, bus.ev_kind_out, bus.ev_src_out);
    end
    model_reset();
    #1 rst = 1'b0;
    bus.ev_ready_in = 1'b1;
    n = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (bus.ev_valid_out !== 1'b0) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL mid_norepeat got=%0d events want=0", n); end
    bus.ev_ready_in = 1'b0; bus.repeat_en_in = 1'b0; bus.src_held_in = '0;
  endtask

  task automatic test_random();
    int r, ek, ec, es, ev, errs;
    do_reset();
    bus.repeat_en_in = 1'b1;
    errs = 0;
    for (int c = 0; c < 800; c++) begin
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 31) == 0) bus.src_held_in[s] = ~bus.src_held_in[s];
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 7);
          set_pulse(s, (r < 5) ? 0 : (r == 5) ? 2 : (r == 6) ? 1 : 3, $urandom_range(0, 65535));
        end
      end
      if ($urandom_range(0, 63) == 0) bus.repeat_en_in = ~bus.repeat_en_in;
      bus.ev_ready_in = ($urandom_range(0, 2) != 0);
      tick();
      ev = (m_q.size() > 0);
      ek = ev ? m_q[0].kind : 0;
      ec = ev ? m_q[0].chr  : 0;
      es = ev ? m_q[0].src  : 0;
      total++;
      if (bus.ev_valid_out !== 1'(ev) || bus.ev_kind_out !== 2'(ek) || bus.ev_char_out !== 16'(ec) ||
          bus.ev_src_out !== 2'(es) || bus.count_out !== 3'(m_q.size()) || bus.drop_count_out !== 8'(m_drop)) begin
        bad++;
        if (errs < 10)
          $display("FAIL rand_cycle%0d got v%0b k%0d c%0h s%0d n%0d d%0d want v%0d k%0d c%0h s%0d n%0d d%0d",
                   c, bus.ev_valid_out, bus.ev_kind_out, bus.ev_char_out, bus.ev_src_out, bus.count_out,
                   bus.drop_count_out, ev, ek, ec, es, m_q.size(), m_drop);
        errs++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.src_valid_in = '0; bus.src_kind_in = '0; bus.src_char_in = '0; bus.src_held_in = '0;
    bus.repeat_en_in = 1'b0; bus.ev_ready_in = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_round_robin();
    test_full_drop();
    test_auto_repeat();
    test_full_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
